// File: rtl/goertzel_result_packer_if.sv
// Stream bundle (data, valid, ready) shared by the packer's input and output.
// Latency: none, wires only.
// Backpressure: tready flows from slave to master.
interface goertzel_result_packer_if #(
    parameter int W = 40
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/goertzel_result_packer.sv
// Rounds/saturates Goertzel {re,im}, adds power, seq and timestamp, queues 128-bit beats.
// Latency: 3 pipeline stages plus FIFO write; first beat valid 4 cycles after input.
// Backpressure: never stalls upstream; when the FIFO is full without a pop the result is dropped and counted.
module goertzel_result_packer #(
    parameter int OW         = 20,
    parameter int FW         = 16,
    parameter int ADC_WIDTH  = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    goertzel_result_packer_if.slave         s_axis,
    goertzel_result_packer_if.master        m_axis,
    output logic [15:0]                     o_drop_count,
    output logic                            o_overflow
);
    localparam int SH = OW - FW;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic signed [OW:0] RND  = (OW+1)'(2 ** (SH - 1));
    localparam logic signed [OW:0] MAXV = (OW+1)'(2 ** (FW - 1) - 1);
    localparam logic signed [OW:0] MINV = -MAXV - (OW+1)'(1);
    localparam logic [AW:0]        FULL = (AW+1)'(FIFO_DEPTH);

    // Round half up (toward +inf), then clamp to the FW-bit two's complement range.
    function automatic logic signed [FW-1:0] rnd_sat(input logic signed [OW-1:0] x);
        logic signed [OW:0] sum;
        logic signed [OW:0] shf;
        logic signed [FW-1:0] res;
        sum = {x[OW-1], x} + RND;
        shf = sum >>> SH;
        if (shf > MAXV) begin
            res = MAXV[FW-1:0];
        end else if (shf < MINV) begin
            res = MINV[FW-1:0];
        end else begin
            res = shf[FW-1:0];
        end
        return res;
    endfunction

    logic [31:0] seq;
    logic [31:0] ts;

    logic                 s1_vld;
    logic signed [OW-1:0] s1_re, s1_im;
    logic [31:0]          s1_seq, s1_ts;

    logic                 s2_vld;
    logic signed [FW-1:0] s2_re, s2_im;
    logic [31:0]          s2_seq, s2_ts;

    logic                 s3_vld;
    logic [ADC_WIDTH-1:0] s3_beat;

    logic signed [2*FW-1:0] re_ext, im_ext;
    logic [2*FW-1:0]        re_sq, im_sq;
    logic [31:0]            power;

    logic [ADC_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 fifo_vld, pop, push, drop;

    assign s_axis.tready = 1'b1;

    // Free-running timestamp and result sequence number (seq counts dropped results too).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ts  <= '0;
            seq <= '0;
        end else begin
            ts  <= ts + 32'd1;
            seq <= seq + {31'b0, s_axis.tvalid};
        end
    end

    // S1: capture raw result with its tags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_vld <= 1'b0;
            s1_re  <= '0;
            s1_im  <= '0;
            s1_seq <= '0;
            s1_ts  <= '0;
        end else begin
            s1_vld <= s_axis.tvalid;
            s1_re  <= s_axis.tdata[2*OW-1:OW];
            s1_im  <= s_axis.tdata[OW-1:0];
            s1_seq <= seq;
            s1_ts  <= ts;
        end
    end

    // S2: round and saturate both components.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_vld <= 1'b0;
            s2_re  <= '0;
            s2_im  <= '0;
            s2_seq <= '0;
            s2_ts  <= '0;
        end else begin
            s2_vld <= s1_vld;
            s2_re  <= rnd_sat(s1_re);
            s2_im  <= rnd_sat(s1_im);
            s2_seq <= s1_seq;
            s2_ts  <= s1_ts;
        end
    end

    // Squares are non-negative and each fits in 2*FW-1 bits, so the sum cannot exceed 2^31.
    assign re_ext = (2*FW)'(s2_re);
    assign im_ext = (2*FW)'(s2_im);
    assign re_sq  = re_ext * re_ext;
    assign im_sq  = im_ext * im_ext;
    assign power  = 32'(re_sq) + 32'(im_sq);

    // S3: compute power and assemble the output beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s3_vld  <= 1'b0;
            s3_beat <= '0;
        end else begin
            s3_vld  <= s2_vld;
            s3_beat <= {s2_seq, power, 16'(s2_re), 16'(s2_im), s2_ts};
        end
    end

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign fifo_vld = (count != '0);
    assign pop      = fifo_vld && m_axis.tready;
    assign push     = s3_vld && ((count < FULL) || pop);
    assign drop     = s3_vld && !push;

    assign m_axis.tvalid = fifo_vld;
    assign m_axis.tdata  = fifo_vld ? mem[rd_ptr] : '0;

    // FIFO storage; stale contents are masked by the empty check, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= s3_beat;
        end
    end

    // FIFO pointers, occupancy and drop accounting.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            o_drop_count <= '0;
            o_overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                o_overflow <= 1'b1;
                if (o_drop_count != 16'hFFFF) begin
                    o_drop_count <= o_drop_count + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_goertzel_result_packer.sv
// Directed bench for goertzel_result_packer.
// Latency: checks the 4-cycle first-beat latency and FIFO ordering.
// Backpressure: exercises full FIFO, drops, pop-while-full and mid-flight reset.
module tb_goertzel_result_packer;
    logic clk = 1'b0;
    logic rst;
    logic [15:0] drop_count;
    logic overflow;

    always #5 clk = ~clk;

    goertzel_result_packer_if #(.W(40))  s_if ();
    goertzel_result_packer_if #(.W(128)) m_if ();

    goertzel_result_packer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .o_drop_count (drop_count),
        .o_overflow   (overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0]  cyc = '0;
    logic [31:0]  exp_seq = '0;
    logic [127:0] exp_q [$];
    logic [127:0] b0, b1;

    // Reference cycle index: zero after a reset edge, +1 per clock after that.
    always @(posedge clk) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + 32'd1;
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [19:0] re, input logic [19:0] im,
                         input logic [15:0] rr, input logic [15:0] ri,
                         input logic [31:0] pw, input bit dropped);
        s_if.tdata  = {re, im};
        s_if.tvalid = 1'b1;
        if (!dropped) exp_q.push_back({exp_seq, pw, rr, ri, cyc});
        exp_seq = exp_seq + 32'd1;
    endtask

    task automatic idle();
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
    endtask

    task automatic get_beat(input string tag, output logic [127:0] got);
        int waited = 0;
        got = '0;
        while (!m_if.tvalid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!m_if.tvalid) begin
            check({tag, "_timeout"}, m_if.tvalid, 1);
        end else if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, m_if.tvalid, 0);
        end else begin
            got = m_if.tdata;
            check(tag, m_if.tdata, exp_q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
        exp_seq = '0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        m_if.tready = 1'b1;
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_tvalid", m_if.tvalid, 0);
        check("rst_tdata", m_if.tdata, 0);
        check("rst_tready", s_if.tready, 1);
        check("rst_drop", drop_count, 0);
        check("rst_ovf", overflow, 0);

        // Test 1: single result, exact latency, ts = 0
        drive(20'h00100, 20'hFFF00, 16'h0010, 16'hFFF0, 32'd512, 1'b0);
        @(negedge clk);
        idle();
        for (int k = 1; k <= 3; k++) begin
            check("t1_early_vld", m_if.tvalid, 0);
            @(negedge clk);
        end
        check("t1_vld", m_if.tvalid, 1);
        check("t1_beat", m_if.tdata, {32'd0, 32'd512, 16'h0010, 16'hFFF0, 32'd0});
        void'(exp_q.pop_front());
        @(negedge clk);
        check("t1_empty", m_if.tvalid, 0);

        // Test 2: saturation and rounding corners
        drive(20'h7FFFF, 20'h80000, 16'h7FFF, 16'h8000, 32'h7FFF0001, 1'b0);
        @(negedge clk); idle();
        get_beat("t2_sat", b0);
        drive(20'h7FFF8, 20'hFFFF8, 16'h7FFF, 16'h0000, 32'h3FFF0001, 1'b0);
        @(negedge clk); idle();
        get_beat("t2_round_hi", b0);
        drive(20'h00018, 20'h00017, 16'h0002, 16'h0001, 32'd5, 1'b0);
        @(negedge clk); idle();
        get_beat("t2_round_pos", b0);
        drive(20'hFFFE8, 20'hFFFE7, 16'hFFFF, 16'hFFFE, 32'd5, 1'b0);
        @(negedge clk); idle();
        get_beat("t2_round_neg", b0);

        // Test 3: backpressure, 6 inputs into a 4-deep FIFO
        do_reset();
        m_if.tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(20'(16 * (i + 1)), 20'h0, 16'(i + 1), 16'h0, 32'((i + 1) * (i + 1)), (i >= 4));
            @(negedge clk);
        end
        idle();
        repeat (4) @(negedge clk);
        check("t3_drop", drop_count, 2);
        check("t3_ovf", overflow, 1);
        check("t3_vld", m_if.tvalid, 1);
        check("t3_head", m_if.tdata, exp_q[0]);
        @(negedge clk);
        check("t3_hold", m_if.tdata, exp_q[0]);
        m_if.tready = 1'b1;
        for (int i = 0; i < 4; i++) get_beat("t3_drain", b0);
        check("t3_empty", m_if.tvalid, 0);

        // Test 4: full FIFO with a pop in the cycle a new result reaches S3
        m_if.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(20'(16 * (i + 10)), 20'h0, 16'(i + 10), 16'h0, 32'((i + 10) * (i + 10)), 1'b0);
            @(negedge clk);
        end
        idle();
        repeat (2) @(negedge clk);
        check("t4_full_vld", m_if.tvalid, 1);
        check("t4_head", m_if.tdata, exp_q[0]);
        m_if.tready = 1'b1;
        @(negedge clk);
        m_if.tready = 1'b0;
        void'(exp_q.pop_front());
        @(negedge clk);
        check("t4_no_drop", drop_count, 2);
        check("t4_next_head", m_if.tdata, exp_q[0]);
        m_if.tready = 1'b1;
        for (int i = 0; i < 4; i++) get_beat("t4_drain", b0);
        check("t4_empty", m_if.tvalid, 0);

        // Test 5: reset with 3 beats queued and 2 in the pipeline
        m_if.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(20'(16 * (i + 20)), 20'h0, 16'(i + 20), 16'h0, 32'((i + 20) * (i + 20)), 1'b0);
            @(negedge clk);
        end
        idle();
        @(negedge clk);
        check("t5_pre_vld", m_if.tvalid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_seq = '0;
        check("t5_vld", m_if.tvalid, 0);
        check("t5_tdata", m_if.tdata, 0);
        check("t5_drop", drop_count, 0);
        check("t5_ovf", overflow, 0);
        m_if.tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t5_no_stale", m_if.tvalid, 0);
        end
        drive(20'h00100, 20'hFFF00, 16'h0010, 16'hFFF0, 32'd512, 1'b0);
        @(negedge clk); idle();
        get_beat("t5_after_rst", b0);
        check("t5_seq0", b0[127:96], 0);

        // Test 6: sequence wrap and timestamp spacing
        force dut.seq = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.seq;
        exp_seq = 32'hFFFF_FFFF;
        drive(20'h00100, 20'hFFF00, 16'h0010, 16'hFFF0, 32'd512, 1'b0);
        @(negedge clk); idle();
        repeat (2) @(negedge clk);
        drive(20'h00018, 20'h00017, 16'h0002, 16'h0001, 32'd5, 1'b0);
        @(negedge clk); idle();
        get_beat("t6_beat0", b0);
        get_beat("t6_beat1", b1);
        check("t6_seq_max", b0[127:96], 32'hFFFF_FFFF);
        check("t6_seq_wrap", b1[127:96], 0);
        check("t6_ts_diff", b1[31:0] - b0[31:0], 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
